// File: rtl/spu32_cpu_div.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: skip a byte of leading zero quotient bits per cycle when possible.
module spu32_cpu_div (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_en,
  input  logic [3:0]  I_op,
  input  logic [31:0] I_s1,
  input  logic [31:0] I_s2,
  output logic [31:0] O_result,
  output logic        O_busy
);

  localparam logic [3:0] ALUOP_DIV  = 4'b1100;
  localparam logic [3:0] ALUOP_DIVU = 4'b1101;
  localparam logic [3:0] ALUOP_REM  = 4'b1110;
  localparam logic [3:0] ALUOP_REMU = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;

  state_e      state_q, state_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] divisor_q, divisor_d;
  logic [5:0]  count_q, count_d;
  logic        is_rem_q, is_rem_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] result_q, result_d;

  logic        is_div_op, signed_op;
  logic [31:0] s1_mag, s2_mag;
  logic [32:0] rem_shift, rem_diff;
  logic [31:0] step_dvd, step_rem;

  assign O_result = result_q;
  assign O_busy   = (state_q != S_IDLE);

  always_comb begin
    is_div_op = (I_op == ALUOP_DIV) || (I_op == ALUOP_DIVU) ||
                (I_op == ALUOP_REM) || (I_op == ALUOP_REMU);
    signed_op = (I_op == ALUOP_DIV) || (I_op == ALUOP_REM);
    s1_mag    = (signed_op && I_s1[31]) ? (~I_s1 + 32'd1) : I_s1;
    s2_mag    = (signed_op && I_s2[31]) ? (~I_s2 + 32'd1) : I_s2;

    // 33-bit compare keeps a divisor magnitude of 0x80000000 exact
    rem_shift = {rem_q, dvd_q[31]};
    rem_diff  = rem_shift - {1'b0, divisor_q};
    if (rem_shift >= {1'b0, divisor_q}) begin
      step_rem = rem_diff[31:0];
      step_dvd = {dvd_q[30:0], 1'b1};
    end else begin
      step_rem = rem_shift[31:0];
      step_dvd = {dvd_q[30:0], 1'b0};
    end
  end

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    count_d   = count_q;
    is_rem_d  = is_rem_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (I_en && is_div_op) begin
          is_rem_d = (I_op == ALUOP_REM) || (I_op == ALUOP_REMU);
          if (I_s2 == '0) begin
            dvd_d   = '1;
            rem_d   = I_s1;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_FIX;
          end else if (signed_op && (I_s1 == 32'h8000_0000) && (I_s2 == '1)) begin
            dvd_d   = 32'h8000_0000;
            rem_d   = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_FIX;
          end else begin
            dvd_d     = s1_mag;
            divisor_d = s2_mag;
            rem_d     = '0;
            qneg_d    = signed_op & (I_s1[31] ^ I_s2[31]);
            rneg_d    = signed_op & I_s1[31];
            count_d   = 6'd32;
            state_d   = S_ITER;
          end
        end
      end
      S_ITER: begin
`ifdef DIV_EARLY_OUT_EN
        if ((rem_q == '0) && (dvd_q[31:24] == 8'h00) && (count_q >= 6'd8)) begin
          dvd_d   = {dvd_q[23:0], 8'h00};
          count_d = count_q - 6'd8;
        end else begin
          dvd_d   = step_dvd;
          rem_d   = step_rem;
          count_d = count_q - 6'd1;
        end
`else
        dvd_d   = step_dvd;
        rem_d   = step_rem;
        count_d = count_q - 6'd1;
`endif
        if (count_d == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (is_rem_q) begin
          result_d = rneg_q ? (~rem_q + 32'd1) : rem_q;
        end else begin
          result_d = qneg_q ? (~dvd_q + 32'd1) : dvd_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q   <= S_IDLE;
      dvd_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      is_rem_q  <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      count_q   <= count_d;
      is_rem_q  <= is_rem_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_spu32_cpu_div.sv
// Self-checking bench for spu32_cpu_div: directed RV32M corner cases plus randomized ops
// checked against plain-arithmetic division semantics.
module tb_spu32_cpu_div;

  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REM  = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] s1 = '0;
  logic [31:0] s2 = '0;
  logic [31:0] result;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  spu32_cpu_div dut (
    .I_clk    (clk),
    .I_reset_n(rst_n),
    .I_en     (en),
    .I_op     (op),
    .I_s1     (s1),
    .I_s2     (s2),
    .O_result (result),
    .O_busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_signed_op(input logic [3:0] o);
    return (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (is_signed_op(o) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (is_signed_op(o)) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return (o == OP_REM || o == OP_REMU) ? r : q;
  endfunction

  // Returns 0 when the exact latency is data dependent (early-out build)
  function automatic int ref_latency(input logic [3:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 0) return 1;
    if (is_signed_op(o) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
    return 0;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return 32'h0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Starts one op, scribbles on the inputs while busy, then checks latency and result
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat);
    int cyc;
    logic [31:0] exp_res;
    exp_res = ref_result(o, a, b);
    @(negedge clk);
    en = 1'b1; op = o; s1 = a; s2 = b;
    @(posedge clk); #1;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      en = 1'($urandom_range(0, 1));
      op = 4'($urandom_range(12, 15));
      s1 = $urandom;
      s2 = $urandom;
      @(posedge clk); #1;
    end
    en = 1'b0;
    if (exp_lat > 0) chk($sformatf("%s.lat", tag), 32'(cyc), 32'(exp_lat));
    else chk($sformatf("%s.lat_le33", tag), 32'(cyc >= 1 && cyc <= 33), 32'd1);
    chk($sformatf("%s.res", tag), result, exp_res);
  endtask

  initial begin
    logic [31:0] held;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          early_lat;

    #12;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DIV_EARLY_OUT_EN
    early_lat = 12;
`else
    early_lat = 33;
`endif

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33);
    held = result;
    repeat (3) @(posedge clk);
    #1 chk("hold.result", result, held);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 33);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 33);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 33);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op("divu_by0", OP_DIVU, 32'h1234_5678, 32'h0, 1);
    run_op("remu_by0", OP_REMU, 32'h1234_5678, 32'h0, 1);
    run_op("div_m5_by0", OP_DIV, 32'hFFFF_FFFB, 32'h0, 1);
    run_op("rem_m5_by0", OP_REM, 32'hFFFF_FFFB, 32'h0, 1);
    run_op("div_min_3", OP_DIV, 32'h8000_0000, 32'd3, 33);
    run_op("divu_big_min", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, early_lat);

    // A non-divide op must neither start nor disturb the held result
    held = result;
    @(negedge clk);
    en = 1'b1; op = 4'b0000; s1 = $urandom; s2 = $urandom;
    @(posedge clk); #1;
    chk("nondiv.busy", 32'(busy), 32'd0);
    chk("nondiv.result", result, held);
    en = 1'b0;

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(12, 15));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rand%0d", i), rop, ra, rb, ref_latency(rop, ra, rb));
    end

    // Async reset in the middle of the iteration
    run_op("pre_reset", OP_DIVU, 32'd1000, 32'd3, 33);
    @(negedge clk);
    en = 1'b1; op = OP_DIVU; s1 = 32'hFFFF_FFFF; s2 = 32'd3;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset.busy", 32'(busy), 32'd0);
    chk("midreset.result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset_9_3", OP_DIVU, 32'd9, 32'd3, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
